// File: rtl/logic_result_serializer.sv
`default_nettype none
//==============================================================================
// Module   : logic_result_serializer
// Purpose  : Waits a settle window after a start request, captures the AND,
//            OR and XOR results of the bitwise stage into one shift register
//            and streams them out MSB-first as bytes over valid/ready.
//            Frame order: ab_and, ab_or, ab_xor, each high byte first.
// Ports    : clk        - rising-edge clock
//            rst_n      - asynchronous active-low reset
//            start      - capture/send request, sampled only in IDLE
//            ab_and     - AND result word   (WIDTH bits)
//            ab_or      - OR result word    (WIDTH bits)
//            ab_xor     - XOR result word   (WIDTH bits)
//            busy       - high whenever the FSM is not IDLE
//            out_data   - current byte (top byte of the shift register)
//            out_valid  - out_data holds a byte to transfer
//            out_ready  - sink accepts the byte
//            out_last   - high with the final byte of a frame
//            done       - one-cycle pulse after the final byte transfers
// Params   : WIDTH      - result word width, multiple of 8 and >= 8
//            SETTLE     - cycles from start to capture (0 = capture on start)
// Revision : 1.0 - initial release
//==============================================================================
module logic_result_serializer #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] ab_and,
  input  logic [WIDTH-1:0] ab_or,
  input  logic [WIDTH-1:0] ab_xor,
  output logic             busy,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             done
);

  // Frame geometry
  localparam int N_BYTES = 3 * WIDTH / 8;
  localparam int SHW     = 3 * WIDTH;
  localparam int IDXW    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int CNTW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [IDXW-1:0] LAST_IDX    = IDXW'(N_BYTES - 1);
  // Only meaningful when SETTLE > 0; with SETTLE == 0 the SETTLE state is
  // never entered.
  localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'((SETTLE > 0) ? (SETTLE - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SEND   = 2'd2
  } state_t;

  state_t            state_q;
  logic [SHW-1:0]    shift_q;
  logic [CNTW-1:0]   cnt_q;
  logic [IDXW-1:0]   idx_q;
  logic              busy_q;
  logic              valid_q;
  logic              last_q;
  logic              done_q;

  // Next-value helpers
  logic [SHW-1:0]    shift_d;
  logic [SHW-1:0]    capture_d;
  logic [IDXW-1:0]   idx_d;

  assign shift_d   = {shift_q[SHW-9:0], 8'h00};
  assign capture_d = {ab_and, ab_or, ab_xor};
  assign idx_d     = idx_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // done is a single-cycle strobe unless re-armed below
      done_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (SETTLE == 0) begin
              // No settle window: the inputs present now are the frame.
              shift_q <= capture_d;
              idx_q   <= '0;
              valid_q <= 1'b1;
              // A frame is always at least 3 bytes, so byte 0 is never last.
              last_q  <= 1'b0;
              state_q <= ST_SEND;
            end else begin
              cnt_q   <= '0;
              state_q <= ST_SETTLE;
            end
          end
        end

        ST_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            shift_q <= capture_d;
            idx_q   <= '0;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
            state_q <= ST_SEND;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_SEND: begin
          // valid_q is always high here, so a transfer is just out_ready.
          // Without a transfer every output register simply holds.
          if (out_ready) begin
            shift_q <= shift_d;
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              idx_q  <= idx_d;
              last_q <= (idx_d == LAST_IDX);
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  // Top byte of the shift register is the byte on offer; after the final
  // shift the register is all zero, so out_data idles at 0x00.
  assign out_data  = shift_q[SHW-1 -: 8];
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_result_serializer.sv
`default_nettype none
//==============================================================================
// Module   : tb_logic_result_serializer
// Purpose  : Scoreboard bench for logic_result_serializer. One instance uses
//            SETTLE=2, a second uses SETTLE=0 for back-to-back framing.
// Revision : 1.0 - initial release
//==============================================================================
module tb_logic_result_serializer;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] a_and = '0, a_or = '0, a_xor = '0;

  // Instance A: SETTLE = 2
  logic start_a = 1'b0, ready_a = 1'b1;
  logic busy_a, valid_a, last_a, done_a;
  logic [7:0] data_a;

  // Instance B: SETTLE = 0
  logic start_b = 1'b0, ready_b = 1'b1;
  logic busy_b, valid_b, last_b, done_b;
  logic [7:0] data_b;

  logic_result_serializer #(.WIDTH(W), .SETTLE(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .ab_and(a_and), .ab_or(a_or), .ab_xor(a_xor),
    .busy(busy_a), .out_data(data_a), .out_valid(valid_a),
    .out_ready(ready_a), .out_last(last_a), .done(done_a)
  );

  logic_result_serializer #(.WIDTH(W), .SETTLE(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .ab_and(a_and), .ab_or(a_or), .ab_xor(a_xor),
    .busy(busy_b), .out_data(data_b), .out_valid(valid_b),
    .out_ready(ready_b), .out_last(last_b), .done(done_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboards: {last, data}
  logic [8:0] qa[$];
  logic [8:0] qb[$];
  int done_cnt_a = 0, exp_done_a = 0, xfer_a = 0;
  int done_cnt_b = 0, exp_done_b = 0;
  int rmode = 0;  // 0: ready_a always 1, 1: ready_a alternates

  // Ready driver for instance A
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ready_a = (rmode == 1) ? ~ready_a : 1'b1;
    end
  end

  // Monitor A
  logic       exp_done_next_a = 1'b0;
  logic       hold_a = 1'b0;
  logic [8:0] hold_val_a;
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      exp_done_next_a = 1'b0;
      hold_a = 1'b0;
    end else begin
      if (done_a || exp_done_next_a) check("A done timing", {31'd0, done_a}, {31'd0, exp_done_next_a});
      if (done_a) done_cnt_a++;
      if (hold_a) begin
        check("A valid held", {31'd0, valid_a}, 32'd1);
        check("A data/last held", {23'd0, last_a, data_a}, {23'd0, hold_val_a});
      end
      exp_done_next_a = 1'b0;
      if (valid_a && ready_a) begin
        if (qa.size() == 0) begin
          total++; bad++;
          $display("FAIL A unexpected byte: got %0h expected none", data_a);
        end else begin
          e = qa.pop_front();
          check("A byte", {23'd0, last_a, data_a}, {23'd0, e});
          exp_done_next_a = e[8];
        end
        xfer_a++;
      end
      hold_a = valid_a && !ready_a;
      hold_val_a = {last_a, data_a};
    end
  end

  // Monitor B
  logic exp_done_next_b = 1'b0;
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      exp_done_next_b = 1'b0;
    end else begin
      if (done_b || exp_done_next_b) check("B done timing", {31'd0, done_b}, {31'd0, exp_done_next_b});
      if (done_b) done_cnt_b++;
      exp_done_next_b = 1'b0;
      if (valid_b && ready_b) begin
        if (qb.size() == 0) begin
          total++; bad++;
          $display("FAIL B unexpected byte: got %0h expected none", data_b);
        end else begin
          e = qb.pop_front();
          check("B byte", {23'd0, last_b, data_b}, {23'd0, e});
          exp_done_next_b = e[8];
        end
      end
    end
  end

  task automatic push_frame(inout logic [8:0] q[$], input logic [W-1:0] x, y, z);
    q.push_back({1'b0, x[15:8]}); q.push_back({1'b0, x[7:0]});
    q.push_back({1'b0, y[15:8]}); q.push_back({1'b0, y[7:0]});
    q.push_back({1'b0, z[15:8]}); q.push_back({1'b1, z[7:0]});
  endtask

  // Called at posedge+1. Returns at posedge+1 after the capture edge.
  task automatic frame_a(input logic [W-1:0] x, y, z);
    a_and = x; a_or = y; a_xor = z;
    push_frame(qa, x, y, z);
    exp_done_a++;
    start_a = 1'b1;
    @(posedge clk); #1;  // t0
    start_a = 1'b0;
    check("A busy after start", {31'd0, busy_a}, 32'd1);
    check("A no valid at t0", {31'd0, valid_a}, 32'd0);
    @(posedge clk); #1;
    check("A no valid at t0+1", {31'd0, valid_a}, 32'd0);
    @(posedge clk); #1;
    check("A valid at t0+2", {31'd0, valid_a}, 32'd1);
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while ((qa.size() != 0 || busy_a) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check("A frame completes in bound", {31'd0, (n < 300)}, 32'd1);
    @(posedge clk); #1;
    check("A done count", done_cnt_a, exp_done_a);
  endtask

  task automatic wait_idle_b();
    int n = 0;
    while ((qb.size() != 0 || busy_b) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check("B frame completes in bound", {31'd0, (n < 300)}, 32'd1);
    @(posedge clk); #1;
    check("B done count", done_cnt_b, exp_done_b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy_a}, 32'd0);
    check("reset valid", {31'd0, valid_a}, 32'd0);
    check("reset last", {31'd0, last_a}, 32'd0);
    check("reset done", {31'd0, done_a}, 32'd0);
    check("reset data", {24'd0, data_a}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame, ready always high
    frame_a(16'hF000, 16'hFFF0, 16'h0FF0);
    wait_idle_a();

    // Same frame with alternating ready
    rmode = 1;
    frame_a(16'hF000, 16'hFFF0, 16'h0FF0);
    wait_idle_a();
    rmode = 0;
    @(posedge clk); #1;

    // Input changes after capture do not affect the frame
    frame_a(16'hF000, 16'hFFF0, 16'h0FF0);
    a_and = 16'h1234; a_or = 16'h5678; a_xor = 16'h9ABC;
    wait_idle_a();
    frame_a(16'h1234, 16'h5678, 16'h9ABC);
    wait_idle_a();

    // start while busy is ignored
    frame_a(16'hA5A5, 16'h5A5A, 16'hC3C3);
    @(posedge clk); #1;
    a_and = 16'h1111; a_or = 16'h2222; a_xor = 16'h3333;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_idle_a();

    // Reset after the 3rd byte aborts the frame
    base = xfer_a;
    frame_a(16'h0102, 16'h0304, 16'h0506);
    n = 0;
    while (xfer_a < base + 3 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("A reached 3rd byte", {31'd0, (n < 100)}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy_a}, 32'd0);
    check("abort valid", {31'd0, valid_a}, 32'd0);
    check("abort last", {31'd0, last_a}, 32'd0);
    check("abort data", {24'd0, data_a}, 32'd0);
    qa.delete();
    exp_done_a--;
    @(posedge clk); #1;
    check("abort no done", {31'd0, done_a}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("no done after abort", {31'd0, done_a}, 32'd0);
    frame_a(16'h0A0B, 16'h0C0D, 16'h0E0F);
    wait_idle_a();

    // SETTLE=0 instance: first byte valid after start edge, back-to-back
    a_and = 16'hDEAD; a_or = 16'hBEEF; a_xor = 16'hCAFE;
    push_frame(qb, 16'hDEAD, 16'hBEEF, 16'hCAFE);
    exp_done_b++;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    check("B valid at t0", {31'd0, valid_b}, 32'd1);
    check("B first byte", {24'd0, data_b}, 32'hDE);
    n = 0;
    while (!done_b && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("B done seen", {31'd0, done_b}, 32'd1);
    a_and = 16'h0123; a_or = 16'h4567; a_xor = 16'h89AB;
    push_frame(qb, 16'h0123, 16'h4567, 16'h89AB);
    exp_done_b++;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    check("B back-to-back valid", {31'd0, valid_b}, 32'd1);
    check("B back-to-back busy", {31'd0, busy_b}, 32'd1);
    wait_idle_b();

    check("A scoreboard empty", qa.size(), 32'd0);
    check("B scoreboard empty", qb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
